// File: rtl/capture_ctl.sv
// Capture sequencer: packs the retimed pixel stream into 64-bit words and
// writes each visible line into one of two line-buffer banks. Software sees
// it through a four-register slave and a level interrupt.
module capture_ctl #(
    parameter int          LB_AW         = 8,
    parameter logic [15:0] LINES_DEFAULT = 16'd480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      vid_pixel,
    input  logic             vid_pixsync,
    input  logic             vid_hblank,
    input  logic             vid_vblank,
    input  logic             vid_visible,
    input  logic             vid_locked,
    input  logic [1:0]       r_address,
    input  logic             r_bus_enable,
    input  logic             r_rw,
    input  logic [31:0]      r_write_data,
    output logic [31:0]      r_read_data,
    output logic             r_acknowledge,
    output logic             r_irq,
    output logic             lb_we,
    output logic             lb_bank,
    output logic [LB_AW-1:0] lb_addr,
    output logic [63:0]      lb_wdata
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_SOF  = 3'd1;
    localparam logic [2:0] ST_WAIT_LINE = 3'd2;
    localparam logic [2:0] ST_CAPTURE   = 3'd3;
    localparam logic [2:0] ST_LINE_END  = 3'd4;

    localparam logic [LB_AW-1:0] IDX_MAX = '1;

    // Register-slave state
    logic [1:0]       r_bus_addr;
    logic             r_bus_rw;
    logic [15:0]      r_bus_wdata;
    logic [3:0]       r_bus_wbits;

    // Control / status state
    logic             r_continuous;
    logic             r_irq_en;
    logic [15:0]      r_lines;
    logic [1:0]       r_bank_full;
    logic             r_wr_bank;
    logic             r_overrun;
    logic             r_irq_pend;
    logic [15:0]      r_line_cnt;
    logic [15:0]      r_frame_cnt;

    // Sequencer state
    logic [2:0]       r_state;
    logic             r_vblank_prev;
    logic             r_hblank_prev;
    logic [LB_AW-1:0] r_word_idx;
    logic             r_idx_full;
    logic             r_skip;
    logic [1:0]       r_pix_cnt;
    logic [11:0]      r_pix [0:2];

    // Upper write-data bits carry no register fields
    logic             w_unused_wdata;
    assign w_unused_wdata = ^r_write_data[31:16];

    // ------------------------------------------------------------------
    // Bus decode (acts during the ack cycle from the latched request)
    // ------------------------------------------------------------------
    logic w_bus_wr;
    logic w_wr_ctrl;
    logic w_wr_status;
    logic w_wr_lines;
    logic w_arm;
    logic w_abort;
    logic [1:0] w_release;
    logic w_clr_ovr;
    logic w_clr_irq;

    assign w_bus_wr    = r_acknowledge & ~r_bus_rw;
    assign w_wr_ctrl   = w_bus_wr & (r_bus_addr == 2'd0);
    assign w_wr_status = w_bus_wr & (r_bus_addr == 2'd1);
    assign w_wr_lines  = w_bus_wr & (r_bus_addr == 2'd2);
    assign w_arm       = w_wr_ctrl & r_bus_wdata[0];
    assign w_abort     = w_wr_ctrl & r_bus_wdata[2];
    assign w_release   = w_wr_status ? r_bus_wdata[1:0] : 2'b00;
    assign w_clr_ovr   = w_wr_status & r_bus_wdata[3];
    assign w_clr_irq   = w_wr_status & r_bus_wbits[0];

    // ------------------------------------------------------------------
    // Video qualifiers
    // ------------------------------------------------------------------
    logic        w_qual_pix;
    logic        w_vblank_fall;
    logic        w_hblank_rise;
    logic        w_stop;
    logic [15:0] w_lines_eff;
    logic [15:0] w_line_inc;

    assign w_qual_pix    = vid_pixsync & vid_visible & ~vid_hblank;
    assign w_vblank_fall = r_vblank_prev & ~vid_vblank;
    assign w_hblank_rise = ~r_hblank_prev & vid_hblank;
    assign w_stop        = (r_state != ST_IDLE) & (w_abort | ~vid_locked);
    assign w_lines_eff   = (r_lines == 16'd0) ? 16'd1 : r_lines;
    assign w_line_inc    = r_line_cnt + 16'd1;

    // ------------------------------------------------------------------
    // Packed words: stored slots plus (for a full word) the live pixel.
    // Unfilled slots are always zero, so the flush word is zero-padded.
    // ------------------------------------------------------------------
    logic [47:0] w_slot_word;
    logic [63:0] w_word_full;
    logic [63:0] w_word_flush;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_slot
            assign w_slot_word[gi*16 +: 16] = {4'b0000, r_pix[gi]};
        end
    endgenerate

    assign w_word_full  = {4'b0000, vid_pixel, w_slot_word};
    assign w_word_flush = {16'h0000, w_slot_word};

    // ------------------------------------------------------------------
    // Sequencer next-state and datapath decisions
    // ------------------------------------------------------------------
    logic [2:0]       w_state_next;
    logic [LB_AW-1:0] w_word_idx_next;
    logic             w_idx_full_next;
    logic             w_skip_next;
    logic [1:0]       w_pix_cnt_next;
    logic [11:0]      w_pix_next [0:2];
    logic [15:0]      w_line_cnt_next;
    logic [15:0]      w_frame_cnt_next;
    logic             w_wr_bank_next;
    logic [1:0]       w_set_full;
    logic             w_set_ovr;
    logic             w_set_irq;
    logic             w_emit;
    logic [63:0]      w_emit_data;

    // Decide state transition, packer update and line-buffer writes
    always_comb begin
        w_state_next     = r_state;
        w_word_idx_next  = r_word_idx;
        w_idx_full_next  = r_idx_full;
        w_skip_next      = r_skip;
        w_pix_cnt_next   = r_pix_cnt;
        w_pix_next       = r_pix;
        w_line_cnt_next  = r_line_cnt;
        w_frame_cnt_next = r_frame_cnt;
        w_wr_bank_next   = r_wr_bank;
        w_set_full       = 2'b00;
        w_set_ovr        = 1'b0;
        w_set_irq        = 1'b0;
        w_emit           = 1'b0;
        w_emit_data      = w_word_full;

        case (r_state)
            ST_IDLE: begin
                if (w_arm && !w_abort && vid_locked) begin
                    w_state_next = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (w_vblank_fall) begin
                    w_state_next    = ST_WAIT_LINE;
                    w_line_cnt_next = 16'd0;
                    w_word_idx_next = '0;
                    w_idx_full_next = 1'b0;
                    w_skip_next     = 1'b0;
                    w_pix_cnt_next  = 2'd0;
                    for (int k = 0; k < 3; k++) w_pix_next[k] = 12'd0;
                end
            end
            ST_WAIT_LINE: begin
                if (w_qual_pix) begin
                    w_state_next  = ST_CAPTURE;
                    // A still-full target bank means software fell behind:
                    // this whole line is dropped and flagged.
                    w_skip_next   = r_bank_full[r_wr_bank];
                    w_set_ovr     = r_bank_full[r_wr_bank];
                    w_set_irq     = r_bank_full[r_wr_bank];
                    w_pix_next[0] = vid_pixel;
                    w_pix_cnt_next = 2'd1;
                end
            end
            ST_CAPTURE: begin
                if (w_hblank_rise) begin
                    w_state_next = ST_LINE_END;
                end else if (w_qual_pix) begin
                    if (r_pix_cnt == 2'd3) begin
                        // Fourth pixel completes a word; past the last
                        // address of the bank words are dropped.
                        if (!r_skip && !r_idx_full) begin
                            w_emit      = 1'b1;
                            w_emit_data = w_word_full;
                            if (r_word_idx == IDX_MAX) begin
                                w_idx_full_next = 1'b1;
                            end else begin
                                w_word_idx_next = r_word_idx + 1'b1;
                            end
                        end
                        w_pix_cnt_next = 2'd0;
                        for (int k = 0; k < 3; k++) w_pix_next[k] = 12'd0;
                    end else begin
                        for (int k = 0; k < 3; k++) begin
                            if (r_pix_cnt == k[1:0]) w_pix_next[k] = vid_pixel;
                        end
                        w_pix_cnt_next = r_pix_cnt + 2'd1;
                    end
                end
            end
            ST_LINE_END: begin
                if ((r_pix_cnt != 2'd0) && !r_skip && !r_idx_full) begin
                    w_emit      = 1'b1;
                    w_emit_data = w_word_flush;
                end
                if (!r_skip) begin
                    w_set_full[r_wr_bank] = 1'b1;
                    w_set_irq             = 1'b1;
                    w_wr_bank_next        = ~r_wr_bank;
                end
                w_pix_cnt_next  = 2'd0;
                for (int k = 0; k < 3; k++) w_pix_next[k] = 12'd0;
                w_line_cnt_next = w_line_inc;
                w_word_idx_next = '0;
                w_idx_full_next = 1'b0;
                w_skip_next     = 1'b0;
                if (w_line_inc >= w_lines_eff) begin
                    w_frame_cnt_next = r_frame_cnt + 16'd1;
                    w_state_next     = r_continuous ? ST_WAIT_SOF : ST_IDLE;
                end else begin
                    w_state_next = ST_WAIT_LINE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Abort or loss of lock discards the line in flight without
        // touching completed banks or the frame count.
        if (w_stop) begin
            w_state_next     = ST_IDLE;
            w_emit           = 1'b0;
            w_pix_cnt_next   = 2'd0;
            for (int k = 0; k < 3; k++) w_pix_next[k] = 12'd0;
            w_word_idx_next  = '0;
            w_idx_full_next  = 1'b0;
            w_skip_next      = 1'b0;
            w_set_full       = 2'b00;
            w_set_ovr        = 1'b0;
            w_set_irq        = 1'b0;
            w_line_cnt_next  = r_line_cnt;
            w_frame_cnt_next = r_frame_cnt;
            w_wr_bank_next   = r_wr_bank;
        end
    end

    // ------------------------------------------------------------------
    // Register read mux (data presented only with the acknowledge)
    // ------------------------------------------------------------------
    logic [31:0] w_rd_mux;

    // Select the register image for the latched address
    always_comb begin
        w_rd_mux = 32'd0;
        case (r_bus_addr)
            2'd0: w_rd_mux = {26'd0, r_state, r_irq_en, r_continuous, 1'b0};
            2'd1: w_rd_mux = {r_line_cnt, 10'd0, r_wr_bank, r_irq_pend,
                              r_overrun, r_bank_full, vid_locked};
            2'd2: w_rd_mux = {16'd0, r_lines};
            default: w_rd_mux = {16'd0, r_frame_cnt};
        endcase
    end

    assign r_read_data = (r_acknowledge && r_bus_rw) ? w_rd_mux : 32'd0;
    assign r_irq       = r_irq_pend & r_irq_en;

    // Register slave handshake: one-cycle ack, request fields latched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acknowledge <= 1'b0;
            r_bus_addr    <= 2'd0;
            r_bus_rw      <= 1'b0;
            r_bus_wdata   <= 16'd0;
            r_bus_wbits   <= 4'd0;
        end else begin
            r_acknowledge <= r_bus_enable & ~r_acknowledge;
            if (r_bus_enable && !r_acknowledge) begin
                r_bus_addr  <= r_address;
                r_bus_rw    <= r_rw;
                r_bus_wdata <= r_write_data[15:0];
                r_bus_wbits <= {3'd0, r_write_data[4]};
            end
        end
    end

    // Control and status registers; set events beat same-cycle clears
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_continuous <= 1'b0;
            r_irq_en     <= 1'b0;
            r_lines      <= LINES_DEFAULT;
            r_bank_full  <= 2'b00;
            r_overrun    <= 1'b0;
            r_irq_pend   <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_continuous <= r_bus_wdata[1];
                r_irq_en     <= r_bus_wdata[3];
            end
            if (w_wr_lines) begin
                r_lines <= r_bus_wdata;
            end
            r_bank_full <= (r_bank_full & ~w_release) | w_set_full;
            r_overrun   <= (r_overrun & ~w_clr_ovr) | w_set_ovr;
            r_irq_pend  <= (r_irq_pend & ~w_clr_irq) | w_set_irq;
        end
    end

    // Sequencer state, counters and pixel packer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_vblank_prev <= 1'b0;
            r_hblank_prev <= 1'b0;
            r_word_idx    <= '0;
            r_idx_full    <= 1'b0;
            r_skip        <= 1'b0;
            r_pix_cnt     <= 2'd0;
            for (int k = 0; k < 3; k++) r_pix[k] <= 12'd0;
            r_line_cnt    <= 16'd0;
            r_frame_cnt   <= 16'd0;
            r_wr_bank     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_vblank_prev <= vid_vblank;
            r_hblank_prev <= vid_hblank;
            r_word_idx    <= w_word_idx_next;
            r_idx_full    <= w_idx_full_next;
            r_skip        <= w_skip_next;
            r_pix_cnt     <= w_pix_cnt_next;
            for (int k = 0; k < 3; k++) r_pix[k] <= w_pix_next[k];
            r_line_cnt    <= w_line_cnt_next;
            r_frame_cnt   <= w_frame_cnt_next;
            r_wr_bank     <= w_wr_bank_next;
        end
    end

    // Line-buffer write port, issued the cycle after a word completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lb_we    <= 1'b0;
            lb_bank  <= 1'b0;
            lb_addr  <= '0;
            lb_wdata <= 64'd0;
        end else begin
            lb_we <= w_emit;
            if (w_emit) begin
                lb_bank  <= r_wr_bank;
                lb_addr  <= r_word_idx;
                lb_wdata <= w_emit_data;
            end
        end
    end

endmodule

// File: tb/tb_capture_ctl.sv
// Directed bench for capture_ctl: drives the video stream and register bus,
// records every line-buffer write and compares against hand-computed values.
module tb_capture_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] vid_pixel = 12'd0;
    logic        vid_pixsync = 1'b0;
    logic        vid_hblank = 1'b1;
    logic        vid_vblank = 1'b0;
    logic        vid_visible = 1'b0;
    logic        vid_locked = 1'b1;
    logic [1:0]  r_address = 2'd0;
    logic        r_bus_enable = 1'b0;
    logic        r_rw = 1'b0;
    logic [31:0] r_write_data = 32'd0;
    logic [31:0] r_read_data;
    logic        r_acknowledge;
    logic        r_irq;
    logic        lb_we;
    logic        lb_bank;
    logic [7:0]  lb_addr;
    logic [63:0] lb_wdata;

    capture_ctl #(.LB_AW(8), .LINES_DEFAULT(16'd480)) dut (
        .clk(clk), .rst(rst),
        .vid_pixel(vid_pixel), .vid_pixsync(vid_pixsync),
        .vid_hblank(vid_hblank), .vid_vblank(vid_vblank),
        .vid_visible(vid_visible), .vid_locked(vid_locked),
        .r_address(r_address), .r_bus_enable(r_bus_enable), .r_rw(r_rw),
        .r_write_data(r_write_data), .r_read_data(r_read_data),
        .r_acknowledge(r_acknowledge), .r_irq(r_irq),
        .lb_we(lb_we), .lb_bank(lb_bank), .lb_addr(lb_addr), .lb_wdata(lb_wdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line-buffer write log
    logic [63:0] q_data [$];
    logic [7:0]  q_addr [$];
    logic        q_bank [$];

    always @(negedge clk) begin
        if (lb_we === 1'b1) begin
            q_data.push_back(lb_wdata);
            q_addr.push_back(lb_addr);
            q_bank.push_back(lb_bank);
            $display("lb write: bank=%0d addr=%0d data=0x%016h", lb_bank, lb_addr, lb_wdata);
        end
    end

    // Rising edges of the interrupt line
    logic irq_prev = 1'b0;
    int   irq_edges = 0;
    always @(negedge clk) begin
        if (r_irq && !irq_prev) irq_edges <= irq_edges + 1;
        irq_prev <= r_irq;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clr_log();
        q_data.delete();
        q_addr.delete();
        q_bank.delete();
    endtask

    task automatic bus(input logic rw, input logic [1:0] a, input logic [31:0] wd,
                       output logic [31:0] rd);
        @(negedge clk);
        r_bus_enable = 1'b1;
        r_rw         = rw;
        r_address    = a;
        r_write_data = wd;
        @(negedge clk);
        chk("ack_hi", 64'(r_acknowledge), 64'd1);
        rd           = r_read_data;
        r_bus_enable = 1'b0;
        @(negedge clk);
        chk("ack_lo", 64'(r_acknowledge), 64'd0);
        $display("bus %s reg%0d wdata=0x%08h rdata=0x%08h", rw ? "rd" : "wr", a, wd, rd);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus(1'b0, a, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        bus(1'b1, a, 32'd0, rd);
        chk(tag, 64'(rd), 64'(exp));
    endtask

    task automatic pix(input logic [11:0] v);
        @(negedge clk);
        vid_pixel   = v;
        vid_pixsync = 1'b1;
        vid_visible = 1'b1;
        @(negedge clk);
        vid_pixsync = 1'b0;
        vid_visible = 1'b0;
    endtask

    task automatic vline(input int n, input logic [11:0] base);
        @(negedge clk);
        vid_hblank = 1'b0;
        for (int i = 0; i < n; i++) pix(12'(int'(base) + i + 1));
        @(negedge clk);
        vid_hblank = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic sof();
        @(negedge clk);
        vid_vblank = 1'b1;
        repeat (2) @(negedge clk);
        vid_vblank = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_entry(input string tag, input int idx, input logic bank,
                             input logic [7:0] addr, input logic [63:0] data);
        logic [63:0] g_data;
        logic [7:0]  g_addr;
        logic        g_bank;
        g_data = (idx < q_data.size()) ? q_data[idx] : 64'hx;
        g_addr = (idx < q_addr.size()) ? q_addr[idx] : 8'hx;
        g_bank = (idx < q_bank.size()) ? q_bank[idx] : 1'bx;
        chk({tag, "_bank"}, 64'(g_bank), 64'(bank));
        chk({tag, "_addr"}, 64'(g_addr), 64'(addr));
        chk({tag, "_data"}, g_data, data);
    endtask

    task automatic reset_checks(input string tag);
        rd_chk({tag, "_ctrl"},   2'd0, 32'h0);
        rd_chk({tag, "_status"}, 2'd1, 32'h1);
        rd_chk({tag, "_lines"},  2'd2, 32'd480);
        rd_chk({tag, "_frames"}, 2'd3, 32'h0);
    endtask

    logic found_we;
    int   irq_base;

    initial begin
        // Reset state of outputs
        repeat (3) @(negedge clk);
        chk("rst_lb_we",   64'(lb_we), 64'd0);
        chk("rst_ack",     64'(r_acknowledge), 64'd0);
        chk("rst_irq",     64'(r_irq), 64'd0);
        chk("rst_wdata",   lb_wdata, 64'd0);
        chk("rst_rdata",   64'(r_read_data), 64'd0);
        rst = 1'b1;
        reset_checks("init");

        // Two 8-pixel lines into alternating banks
        clr_log();
        wr(2'd2, 32'd2);
        wr(2'd0, 32'h1);
        rd_chk("t1_armed", 2'd0, 32'h8);
        sof();
        vline(8, 12'd0);
        vline(8, 12'd8);
        chk("t1_count", 64'(q_data.size()), 64'd4);
        chk_entry("t1_w0", 0, 1'b0, 8'd0, 64'h0004_0003_0002_0001);
        chk_entry("t1_w1", 1, 1'b0, 8'd1, 64'h0008_0007_0006_0005);
        chk_entry("t1_w2", 2, 1'b1, 8'd0, 64'h000C_000B_000A_0009);
        chk_entry("t1_w3", 3, 1'b1, 8'd1, 64'h0010_000F_000E_000D);
        rd_chk("t1_status", 2'd1, 32'h0002_0017);
        rd_chk("t1_frames", 2'd3, 32'd1);
        rd_chk("t1_ctrl",   2'd0, 32'h0);

        // Six-pixel line: second word is the zero-padded flush
        clr_log();
        wr(2'd1, 32'h13);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'h1);
        sof();
        vline(6, 12'd0);
        chk("t2_count", 64'(q_data.size()), 64'd2);
        chk_entry("t2_w0", 0, 1'b0, 8'd0, 64'h0004_0003_0002_0001);
        chk_entry("t2_w1", 1, 1'b0, 8'd1, 64'h0000_0000_0006_0005);
        rd_chk("t2_frames", 2'd3, 32'd2);

        // Banks never released: third line overruns
        clr_log();
        wr(2'd1, 32'h13);
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h1);
        sof();
        vline(4, 12'd0);
        vline(4, 12'd0);
        vline(4, 12'd0);
        chk("t3_count", 64'(q_data.size()), 64'd2);
        chk_entry("t3_w0", 0, 1'b1, 8'd0, 64'h0004_0003_0002_0001);
        chk_entry("t3_w1", 1, 1'b0, 8'd0, 64'h0004_0003_0002_0001);
        rd_chk("t3_status", 2'd1, 32'h0003_003F);
        wr(2'd1, 32'h8);
        rd_chk("t3_ovr_clr", 2'd1, 32'h0003_0037);
        rd_chk("t3_frames", 2'd3, 32'd3);

        // Reset, then continuous capture with interrupt-driven release
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        reset_checks("t4_rst");
        wr(2'd2, 32'd4);
        wr(2'd0, 32'hB);
        rd_chk("t4_ctrl", 2'd0, 32'hE);
        irq_base = irq_edges;
        for (int f = 0; f < 3; f++) begin
            sof();
            for (int l = 0; l < 4; l++) begin
                vline(4, 12'(l * 4));
                chk("t4_irq_on", 64'(r_irq), 64'd1);
                wr(2'd1, 32'h13);
                chk("t4_irq_off", 64'(r_irq), 64'd0);
            end
        end
        chk("t4_irq_edges", 64'(irq_edges - irq_base), 64'd12);
        rd_chk("t4_frames", 2'd3, 32'd3);
        rd_chk("t4_status", 2'd1, 32'h0004_0001);
        rd_chk("t4_ctrl_end", 2'd0, 32'hE);

        // Lock drop mid-line, then re-arm and resume at next vblank fall
        clr_log();
        sof();
        @(negedge clk);
        vid_hblank = 1'b0;
        for (int i = 1; i <= 5; i++) pix(12'(i));
        @(negedge clk);
        vid_locked = 1'b0;
        rd_chk("t5_unlock_idle", 2'd0, 32'h6);
        pix(12'd6);
        @(negedge clk);
        vid_hblank = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_count_unlock", 64'(q_data.size()), 64'd1);
        chk_entry("t5_w0", 0, 1'b0, 8'd0, 64'h0004_0003_0002_0001);
        vid_locked = 1'b1;
        wr(2'd0, 32'hB);
        rd_chk("t5_rearm", 2'd0, 32'hE);
        vline(4, 12'h010);
        chk("t5_count_nosof", 64'(q_data.size()), 64'd1);
        sof();
        vline(4, 12'h010);
        chk("t5_count_resume", 64'(q_data.size()), 64'd2);
        chk_entry("t5_w1", 1, 1'b0, 8'd0, 64'h0014_0013_0012_0011);

        // Bus abort mid-line
        clr_log();
        fork
            vline(8, 12'h020);
            begin
                repeat (2) @(negedge clk);
                wr(2'd0, 32'hE);
            end
        join
        chk("t6_count_abort", 64'(q_data.size()), 64'd0);
        rd_chk("t6_ctrl", 2'd0, 32'h6);

        // Asynchronous reset while a line-buffer write is in flight
        wr(2'd0, 32'hB);
        sof();
        found_we = 1'b0;
        fork
            vline(8, 12'h030);
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk);
                    #1;
                    if (lb_we) begin
                        found_we = 1'b1;
                        break;
                    end
                end
                chk("t7_we_seen", 64'(found_we), 64'd1);
                rst = 1'b0;
                #1;
                chk("t7_we_drop", 64'(lb_we), 64'd0);
            end
        join
        repeat (2) @(negedge clk);
        rst = 1'b1;
        reset_checks("t7_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
